// File: rtl/memory_stream_writer.sv
// Burst writer: takes words from a valid/ready stream and writes them to
// consecutive, wrapping addresses of an external single-port RAM.
module memory_stream_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_written,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH:0]   burst_len;
    logic [ADDR_WIDTH:0]   clamped_len;
    logic                  accept;
    logic                  last_word;
    logic                  launch;

    assign clamped_len = (length > DEPTH) ? DEPTH : length;
    assign accept      = in_valid & in_ready;
    assign last_word   = ((words_written + COUNT_ONE) == burst_len);
    assign launch      = (state_q == IDLE) & start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (clamped_len == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && last_word) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The RAM port is registered, so each write lands one cycle after its accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_addr      <= '0;
            burst_len     <= '0;
            words_written <= '0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_data      <= '0;
        end else begin
            mem_we <= accept;
            if (launch) begin
                cur_addr      <= base_addr;
                burst_len     <= clamped_len;
                words_written <= '0;
            end
            if (accept) begin
                mem_addr      <= cur_addr;
                mem_data      <= in_data;
                cur_addr      <= cur_addr + ADDR_ONE;
                words_written <= words_written + COUNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_memory_stream_writer.sv
// Self-checking bench for memory_stream_writer: per-cycle comparison against a
// burst-level model, a RAM image check, and directed literal expectations.
module tb_memory_stream_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  base_addr = '0;
    logic [4:0]  length = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic [4:0]  words_written;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [31:0] mem_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [16] = '{default: 32'h0};
    logic [31:0] exp_mem [16] = '{default: 32'h0};
    int          wr_log [$];
    bit          last_done_we = 1'b0;

    // Model: phase 0 = idle, 1 = collecting words, 2 = end-of-burst cycle.
    int          m_phase = 0;
    int          m_remaining = 0;
    int          m_next = 0;
    int          m_count = 0;
    bit          m_we = 1'b0;
    int          m_addr = 0;
    logic [31:0] m_data = '0;

    memory_stream_writer #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .length(length),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .busy(busy),
        .done(done),
        .words_written(words_written),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_data;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_remaining = 0; m_next = 0; m_count = 0;
            m_we = 1'b0; m_addr = 0; m_data = '0;
        end else begin
            int clen;
            if (m_we) exp_mem[m_addr] = m_data;
            m_we = 1'b0;
            case (m_phase)
                0: if (start) begin
                    clen = (int'(length) > 16) ? 16 : int'(length);
                    m_count = 0;
                    if (clen == 0) m_phase = 2;
                    else begin
                        m_phase = 1; m_remaining = clen; m_next = int'(base_addr);
                    end
                end
                1: if (in_valid) begin
                    m_we = 1'b1; m_addr = m_next; m_data = in_data;
                    m_next = (m_next + 1) % 16;
                    m_count++; m_remaining--;
                    if (m_remaining == 0) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("in_ready", 64'(in_ready), 64'(m_phase == 1));
        checkOutput("busy", 64'(busy), 64'(m_phase != 0));
        checkOutput("done", 64'(done), 64'(m_phase == 2));
        checkOutput("words_written", 64'(words_written), 64'(m_count));
        checkOutput("mem_we", 64'(mem_we), 64'(m_we));
        checkOutput("mem_addr", 64'(mem_addr), 64'(m_addr));
        checkOutput("mem_data", 64'(mem_data), 64'(m_data));
        if (!reset && mem_we) wr_log.push_back(int'(mem_addr));
        if (!reset && done) last_done_we = mem_we;
    end

    task automatic startBurst(input int b, input int len);
        start = 1'b1; base_addr = b[3:0]; length = len[4:0]; in_valid = 1'b0;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] vpat, input bit rnd,
                                 input logic [31:0] dbase, input int poke_at);
        int nacc = 0;
        bit finished = 1'b0;
        for (int i = 0; i < 200 && !finished; i++) begin
            if (done) finished = 1'b1;
            else begin
                in_valid = rnd ? 1'($urandom_range(0, 1)) : (i < 32 ? vpat[i] : 1'b1);
                in_data  = dbase + 32'(nacc);
                start    = (i == poke_at);
                if (start) begin
                    base_addr = 4'($urandom);
                    length    = 5'($urandom_range(1, 31));
                end
                if (in_valid) nacc++;
                @(posedge clk); #2;
            end
        end
        in_valid = 1'b0; start = 1'b0;
        checkOutput("burst_timeout", 64'(finished), 64'd1);
    endtask

    task automatic compareMem();
        for (int a = 0; a < 16; a++) checkOutput("ram_image", 64'(ram[a]), 64'(exp_mem[a]));
    endtask

    initial begin
        #1 reset = 1'b1;
        @(posedge clk); #2;
        checkOutput("reset_mem_we", 64'(mem_we), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_count", 64'(words_written), 64'd0);
        checkOutput("reset_addr", 64'(mem_addr), 64'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #2;

        // Basic burst
        wr_log.delete();
        startBurst(2, 4);
        applyStimulus(32'hFFFF_FFFF, 1'b0, 32'hA0, -1);
        @(posedge clk); #2;
        checkOutput("basic_nwrites", 64'(wr_log.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            checkOutput("basic_addr", 64'(wr_log[k]), 64'(2 + k));
            checkOutput("basic_data", 64'(ram[2 + k]), 64'(32'hA0 + k));
        end
        checkOutput("basic_done_with_we", 64'(last_done_we), 64'd1);
        checkOutput("basic_count", 64'(words_written), 64'd4);

        // Wrap with stalls: valid pattern 1,0,1,0,1,1
        wr_log.delete();
        startBurst(14, 4);
        applyStimulus(32'hFFFF_FFF5, 1'b0, 32'hB0, -1);
        @(posedge clk); #2;
        checkOutput("wrap_nwrites", 64'(wr_log.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            checkOutput("wrap_addr", 64'(wr_log[k]), 64'((14 + k) % 16));
            checkOutput("wrap_data", 64'(ram[(14 + k) % 16]), 64'(32'hB0 + k));
        end
        checkOutput("wrap_ready_after", 64'(in_ready), 64'd0);

        // Zero length
        wr_log.delete();
        startBurst(5, 0);
        checkOutput("zero_done", 64'(done), 64'd1);
        applyStimulus(32'hFFFF_FFFF, 1'b0, 32'hEE, -1);
        @(posedge clk); #2;
        checkOutput("zero_nwrites", 64'(wr_log.size()), 64'd0);
        checkOutput("zero_count", 64'(words_written), 64'd0);

        // Clamp 31 -> 16
        wr_log.delete();
        startBurst(0, 31);
        applyStimulus(32'hFFFF_FFFF, 1'b0, 32'hC0, -1);
        @(posedge clk); #2;
        checkOutput("clamp_nwrites", 64'(wr_log.size()), 64'd16);
        checkOutput("clamp_count", 64'(words_written), 64'd16);
        compareMem();

        // Ignored start during WRITE, then a back-to-back burst
        wr_log.delete();
        startBurst(3, 6);
        applyStimulus(32'h0, 1'b1, 32'hD0, 2);
        @(posedge clk); #2;
        startBurst(10, 3);
        applyStimulus(32'hFFFF_FFFF, 1'b0, 32'hE0, -1);
        @(posedge clk); #2;
        checkOutput("b2b_nwrites", 64'(wr_log.size()), 64'd9);
        for (int k = 0; k < 6; k++) checkOutput("b2b_first", 64'(ram[3 + k]), 64'(32'hD0 + k));
        for (int k = 0; k < 3; k++) checkOutput("b2b_second", 64'(ram[10 + k]), 64'(32'hE0 + k));
        checkOutput("b2b_count", 64'(words_written), 64'd3);

        // Reset mid-burst with the fourth write still pending
        startBurst(9, 8);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 32'hF0 + 32'(k);
            @(posedge clk); #2;
        end
        checkOutput("midrst_we_before", 64'(mem_we), 64'd1);
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        checkOutput("midrst_we", 64'(mem_we), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_count", 64'(words_written), 64'd0);
        for (int k = 0; k < 3; k++) checkOutput("midrst_ram", 64'(ram[9 + k]), 64'(32'hF0 + k));
        @(posedge clk); #2;

        // Randomized bursts
        for (int n = 0; n < 8; n++) begin
            startBurst(int'($urandom_range(0, 15)), int'($urandom_range(0, 24)));
            applyStimulus(32'h0, 1'b1, $urandom, (n % 2 == 0) ? 1 : -1);
            @(posedge clk); #2;
            compareMem();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
